// File: rtl/chan_arb_pkg.sv
// -----------------------------------------------------------------------------
// chan_arb_pkg
// Shared widths, defaults and FSM state encoding for channel_bus_arbiter.
//   CHAN_W       : channel address width (octal 00..77)
//   DATA_W       : channel data width (bits 1-14 and 16 of the word)
//   NREQ_DEFAULT : default number of channel requesters
//   CNT_W        : width of the strobe-length counter (STROBE_CYC 1..7)
//   state_t      : IDLE -> ADDR -> STROBE -> DONE transaction sequence
// -----------------------------------------------------------------------------
package chan_arb_pkg;

  localparam int CHAN_W       = 6;
  localparam int DATA_W       = 15;
  localparam int NREQ_DEFAULT = 4;
  localparam int CNT_W        = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search begins at index ptr
// and wraps modulo NREQ; the first requester found wins.
//   req   [NREQ-1:0]  : request vector
//   ptr   [PTR_W-1:0] : index where the search starts (must be < NREQ)
//   gnt   [NREQ-1:0]  : one-hot grant, all zero when nothing requested
//   valid             : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic             valid
);

  logic [2*NREQ-1:0] req_dbl;
  logic [2*NREQ-1:0] gnt_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   gnt_rot;

  // Rotate so that index ptr lands in bit 0, take the lowest set bit, then
  // rotate the one-hot result back. Doubling the vector makes the rotate a
  // plain shift for any NREQ, power of two or not.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NREQ-1:0];
    gnt_rot = req_rot & (-req_rot);
    gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    gnt     = gnt_dbl[2*NREQ-1:NREQ];
    valid   = |req;
  end

endmodule

// File: rtl/channel_bus_arbiter.sv
// -----------------------------------------------------------------------------
// channel_bus_arbiter
// Arbitrates NREQ requesters onto a single channel bus. Each transaction runs
// IDLE -> ADDR (1 cycle) -> STROBE (STROBE_CYC cycles) -> DONE (1 cycle).
// Reads pulse RCH_ low and capture ~CHOR_; writes pulse WCH_ low with
// CHWL_ = ~wdata. All outputs are registered.
//
// Optional feature (macro CHAN_LOCK_EN): a requester holding lock and req in
// DONE goes straight back to ADDR without re-arbitration. Without the macro
// the lock input is ignored.
//
// Ports:
//   CLOCK                 : clock, rising edge
//   rst                   : asynchronous active-high reset
//   req   [NREQ]          : level request per requester
//   we    [NREQ]          : 1 write, 0 read
//   chan  [NREQ][CHAN_W]  : channel address per requester
//   wdata [NREQ][DATA_W]  : write data per requester
//   lock  [NREQ]          : hold-grant request (CHAN_LOCK_EN only)
//   CHOR_ [DATA_W]        : channel OR bus, active-low
//   gnt   [NREQ]          : one-hot grant, ADDR through DONE
//   done  [NREQ]          : one-cycle completion pulse
//   rdata [DATA_W]        : read data, true polarity, held until next read
//   ch_addr [CHAN_W]      : channel address to decoders
//   RCH_, WCH_            : read / write strobes, active-low
//   CHWL_ [DATA_W]        : write lines, active-low, all ones when idle
// -----------------------------------------------------------------------------
module channel_bus_arbiter
  import chan_arb_pkg::*;
#(
  parameter int NREQ       = NREQ_DEFAULT,
  parameter int STROBE_CYC = 2
) (
  input  logic                         CLOCK,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              we,
  input  logic [NREQ-1:0][CHAN_W-1:0]  chan,
  input  logic [NREQ-1:0][DATA_W-1:0]  wdata,
  input  logic [NREQ-1:0]              lock,
  input  logic [DATA_W-1:0]            CHOR_,
  output logic [NREQ-1:0]              gnt,
  output logic [NREQ-1:0]              done,
  output logic [DATA_W-1:0]            rdata,
  output logic [CHAN_W-1:0]            ch_addr,
  output logic                         RCH_,
  output logic                         WCH_,
  output logic [DATA_W-1:0]            CHWL_
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYC - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [PTR_W-1:0]   cur_idx, idx_n;
  logic               cur_we, we_n;
  logic [DATA_W-1:0]  cur_wdata, wdata_n;

  logic [NREQ-1:0]    gnt_n, done_n;
  logic [DATA_W-1:0]  rdata_n, chwl_n;
  logic [CHAN_W-1:0]  ch_addr_n;
  logic               rch_n, wch_n;

  logic [NREQ-1:0]    arb_gnt;
  logic               arb_valid;
  logic [PTR_W-1:0]   arb_idx;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) arb_idx = PTR_W'(i);
    end
  end

`ifndef CHAN_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered so that the register stage presents them in that state;
  // the requester's chan/we/wdata are captured on the edge into ADDR so
  // ch_addr is already valid during ADDR.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path through
    // this block leaves one unassigned, which would infer a latch.
    state_n   = state;
    cnt_n     = cnt;
    ptr_n     = ptr;
    idx_n     = cur_idx;
    we_n      = cur_we;
    wdata_n   = cur_wdata;
    gnt_n     = gnt;
    done_n    = '0;
    rdata_n   = rdata;
    ch_addr_n = ch_addr;
    rch_n     = 1'b1;
    wch_n     = 1'b1;
    chwl_n    = '1;

    unique case (state)
      IDLE: begin
        gnt_n = '0;
        if (arb_valid) begin
          state_n   = ADDR;
          gnt_n     = arb_gnt;
          idx_n     = arb_idx;
          ptr_n     = (arb_idx == PTR_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          ch_addr_n = chan[arb_idx];
          we_n      = we[arb_idx];
          wdata_n   = wdata[arb_idx];
        end
      end

      ADDR: begin
        state_n = STROBE;
        cnt_n   = '0;
        rch_n   = cur_we;
        wch_n   = ~cur_we;
        if (cur_we) chwl_n = ~cur_wdata;
      end

      STROBE: begin
        if (cnt == CNT_LAST) begin
          // Leaving the last strobe cycle: strobes release and read data is
          // sampled on this same edge.
          state_n = DONE;
          done_n  = gnt;
          if (!cur_we) rdata_n = ~CHOR_;
        end else begin
          cnt_n = cnt + 1'b1;
          rch_n = cur_we;
          wch_n = ~cur_we;
          if (cur_we) chwl_n = ~cur_wdata;
        end
      end

      DONE: begin
        state_n = IDLE;
        gnt_n   = '0;
`ifdef CHAN_LOCK_EN
        // Locked requester keeps the bus; pointer is left untouched so
        // arbitration resumes where it would have without the lock.
        if (lock[cur_idx] && req[cur_idx]) begin
          state_n   = ADDR;
          gnt_n     = gnt;
          ch_addr_n = chan[cur_idx];
          we_n      = we[cur_idx];
          wdata_n   = wdata[cur_idx];
        end
`endif
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      cur_idx   <= '0;
      cur_we    <= 1'b0;
      cur_wdata <= '0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      ch_addr   <= '0;
      RCH_      <= 1'b1;
      WCH_      <= 1'b1;
      CHWL_     <= '1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ptr       <= ptr_n;
      cur_idx   <= idx_n;
      cur_we    <= we_n;
      cur_wdata <= wdata_n;
      gnt       <= gnt_n;
      done      <= done_n;
      rdata     <= rdata_n;
      ch_addr   <= ch_addr_n;
      RCH_      <= rch_n;
      WCH_      <= wch_n;
      CHWL_     <= chwl_n;
    end
  end

endmodule

// File: tb/tb_channel_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_channel_bus_arbiter
// Directed bench for channel_bus_arbiter at default parameters. Stimulus
// pushes the expected transaction (requester, direction, channel, data) into
// a scoreboard queue; an independent monitor pops and compares on each done
// pulse and checks bus lines while a strobe is active. Cycle-exact checks
// cover latency, strobe timing and reset behaviour.
// Expectations for the lock sequence follow CHAN_LOCK_EN.
// -----------------------------------------------------------------------------
module tb_channel_bus_arbiter;

  localparam int NREQ = 4;

  typedef struct {
    int          idx;
    logic        we;
    logic [5:0]  chan;
    logic [14:0] data;
  } exp_t;

  logic                  CLOCK = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req, we, lock;
  logic [NREQ-1:0][5:0]  chan;
  logic [NREQ-1:0][14:0] wdata;
  logic [14:0]           CHOR_;
  logic [NREQ-1:0]       gnt, done;
  logic [14:0]           rdata, CHWL_;
  logic [5:0]            ch_addr;
  logic                  RCH_, WCH_;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_done = 0;

  channel_bus_arbiter #(.NREQ(NREQ), .STROBE_CYC(2)) dut (
    .CLOCK   (CLOCK),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .chan    (chan),
    .wdata   (wdata),
    .lock    (lock),
    .CHOR_   (CHOR_),
    .gnt     (gnt),
    .done    (done),
    .rdata   (rdata),
    .ch_addr (ch_addr),
    .RCH_    (RCH_),
    .WCH_    (WCH_),
    .CHWL_   (CHWL_)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input logic w, input logic [5:0] ch, input logic [14:0] d);
    exp_t e;
    e.idx = idx; e.we = w; e.chan = ch; e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_dones(input int target, input int budget);
    logic hit = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLOCK); #1;
      if (n_done >= target) begin
        hit = 1'b1;
        break;
      end
    end
    check("done_wait_budget", {31'd0, hit}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    lock = '0;
    sb.delete();
    repeat (2) @(negedge CLOCK);
    rst = 1'b0;
    @(negedge CLOCK);
  endtask

  // Monitor: bus-line checks during strobes and scoreboard pop on done.
  initial begin
    exp_t        e;
    logic [14:0] inv;
    forever begin
      @(negedge CLOCK);
      if (!rst) begin
        check("strobe_exclusive", {31'd0, RCH_ | WCH_}, 32'd1);
        check("gnt_onehot", {31'd0, $countones(gnt) <= 1}, 32'd1);
        if ((!RCH_ || !WCH_) && sb.size() > 0) begin
          check("strobe_addr", ch_addr, sb[0].chan);
          check("strobe_dir", {31'd0, RCH_}, {31'd0, sb[0].we});
          if (!WCH_) begin
            inv = ~sb[0].data;
            check("strobe_chwl", CHWL_, inv);
          end
        end
        if (|done) begin
          n_done++;
          if (sb.size() == 0) begin
            check("done_unexpected", done, 32'd0);
          end else begin
            e = sb.pop_front();
            check("done_idx", done, 32'd1 << e.idx);
            check("done_gnt", gnt, 32'd1 << e.idx);
            check("done_addr", ch_addr, e.chan);
            if (!e.we) check("done_rdata", rdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    logic [14:0] inv;
    int base;

    rst = 1'b1; req = '0; we = '0; lock = '0; chan = '0; wdata = '0; CHOR_ = '1;
    repeat (2) @(negedge CLOCK);
    check("rst_gnt",   gnt,     32'd0);
    check("rst_done",  done,    32'd0);
    check("rst_rch",   RCH_,    32'd1);
    check("rst_wch",   WCH_,    32'd1);
    check("rst_chwl",  CHWL_,   32'h7fff);
    check("rst_rdata", rdata,   32'd0);
    check("rst_addr",  ch_addr, 32'd0);
    rst = 1'b0;
    @(negedge CLOCK);

    // Single read from requester 0, cycle-exact; req withdrawn after ADDR.
    chan[0] = 6'o30; we[0] = 1'b0; CHOR_ = ~15'o12345;
    push(0, 1'b0, 6'o30, 15'o12345);
    req[0] = 1'b1;
    @(negedge CLOCK);
    check("rd_c1_gnt",  gnt,     32'd1);
    check("rd_c1_rch",  RCH_,    32'd1);
    check("rd_c1_addr", ch_addr, 32'o30);
    req[0] = 1'b0;
    @(negedge CLOCK);
    check("rd_c2_rch", RCH_, 32'd0);
    @(negedge CLOCK);
    check("rd_c3_rch", RCH_, 32'd0);
    @(negedge CLOCK);
    check("rd_c4_done", done, 32'd1);
    check("rd_c4_rch",  RCH_, 32'd1);
    @(negedge CLOCK);
    check("rd_c5_gnt",   gnt,   32'd0);
    check("rd_c5_rdata", rdata, 32'o12345);

    // Single write from requester 2 (pointer now at 1).
    we[2] = 1'b1; chan[2] = 6'o11; wdata[2] = 15'o07070;
    push(2, 1'b1, 6'o11, 15'o07070);
    req[2] = 1'b1;
    @(negedge CLOCK);
    check("wr_c1_gnt",  gnt,     32'd4);
    check("wr_c1_wch",  WCH_,    32'd1);
    check("wr_c1_addr", ch_addr, 32'o11);
    req[2] = 1'b0;
    inv = ~15'o07070;
    for (int c = 2; c <= 3; c++) begin
      @(negedge CLOCK);
      check("wr_strobe_wch",  WCH_,    32'd0);
      check("wr_strobe_rch",  RCH_,    32'd1);
      check("wr_strobe_chwl", CHWL_,   inv);
      check("wr_strobe_addr", ch_addr, 32'o11);
    end
    @(negedge CLOCK);
    check("wr_c4_done",  done,  32'd4);
    check("wr_c4_wch",   WCH_,  32'd1);
    check("wr_c4_chwl",  CHWL_, 32'h7fff);
    check("wr_c4_rdata", rdata, 32'o12345);
    @(negedge CLOCK);

    // All four requesting: order 0,1,2,3,0 from a fresh pointer.
    do_reset();
    CHOR_ = ~15'o54321;
    for (int i = 0; i < NREQ; i++) begin
      we[i] = 1'b0;
      chan[i] = 6'(8 * i + 3);
    end
    push(0, 1'b0, 6'o03, 15'o54321);
    push(1, 1'b0, 6'o13, 15'o54321);
    push(2, 1'b0, 6'o23, 15'o54321);
    push(3, 1'b0, 6'o33, 15'o54321);
    push(0, 1'b0, 6'o03, 15'o54321);
    base = n_done;
    req = '1;
    wait_dones(base + 5, 60);
    req = '0;
    repeat (3) @(negedge CLOCK);

    // Reset in the middle of a write strobe.
    we[2] = 1'b1; chan[2] = 6'o22; wdata[2] = 15'o11111;
    req[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLOCK);
      if (!WCH_) break;
    end
    check("mid_reached_strobe", WCH_, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_wch",   WCH_,    32'd1);
    check("mid_rst_gnt",   gnt,     32'd0);
    check("mid_rst_chwl",  CHWL_,   32'h7fff);
    check("mid_rst_addr",  ch_addr, 32'd0);
    check("mid_rst_rdata", rdata,   32'd0);
    req = '0;
    we[2] = 1'b0; chan[2] = 6'o23;
    @(negedge CLOCK);
    rst = 1'b0;
    @(negedge CLOCK);
    push(0, 1'b0, 6'o03, 15'o54321);
    base = n_done;
    req = '1;
    wait_dones(base + 1, 20);
    req = '0;
    repeat (3) @(negedge CLOCK);

    // Lock sequence: requester 1 locks while 0 also requests.
    do_reset();
    chan[0] = 6'o40; chan[1] = 6'o41;
    lock[1] = 1'b1;
`ifdef CHAN_LOCK_EN
    push(1, 1'b0, 6'o41, 15'o54321);
    push(1, 1'b0, 6'o41, 15'o54321);
    push(1, 1'b0, 6'o41, 15'o54321);
    push(0, 1'b0, 6'o40, 15'o54321);
`else
    push(1, 1'b0, 6'o41, 15'o54321);
    push(0, 1'b0, 6'o40, 15'o54321);
    push(1, 1'b0, 6'o41, 15'o54321);
    push(0, 1'b0, 6'o40, 15'o54321);
`endif
    base = n_done;
    req[1] = 1'b1;
    @(negedge CLOCK);
    req[0] = 1'b1;
    wait_dones(base + 2, 30);
    @(posedge CLOCK); #1;
    lock[1] = 1'b0;
    wait_dones(base + 4, 40);
    req = '0;

    repeat (5) @(negedge CLOCK);
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/channel_bus_arbiter.md
CHANNEL_BUS_ARBITER -- requirements
Module: channel_bus_arbiter

Interface
REQ-001 Parameter NREQ, default 4, meaning number of channel requesters.
REQ-002 Parameter STROBE_CYC, default 2, meaning number of cycles the RCH/WCH strobe is held low (legal 1..7).
REQ-003 CLOCK  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester access request, level.
REQ-006 we  input  NREQ  per-requester direction: 1 write, 0 read.
REQ-007 chan  input  NREQ x 6  per-requester channel address (octal 00..77).
REQ-008 wdata  input  NREQ x 15  per-requester write data, bits 1-14 and 16.
REQ-009 lock  input  NREQ  per-requester hold-grant request (see Configuration).
REQ-010 CHOR_  input  15  channel OR bus from channel logic, active-low.
REQ-011 gnt  output  NREQ  one-hot grant, high from ADDR through DONE.
REQ-012 done  output  NREQ  one-cycle completion pulse to granted requester.
REQ-013 rdata  output  15  read data, true polarity, valid in DONE cycle and held until next capture.
REQ-014 ch_addr  output  6  channel address to channel decoders.
REQ-015 RCH_  output  1  channel read strobe, active-low.
REQ-016 WCH_  output  1  channel write strobe, active-low.
REQ-017 CHWL_  output  15  channel write lines, active-low; all ones when not writing.

Function
REQ-018 FSM states SHALL be IDLE, ADDR, STROBE, DONE; all outputs registered.
REQ-019 IDLE: sample req; if any set, grant one by round-robin and go ADDR; else stay IDLE.
REQ-020 Round-robin: search starts at index (last granted + 1) mod NREQ; after reset search starts at 0.
REQ-021 ADDR (1 cycle): latch granted chan/we/wdata; drive ch_addr; strobes high.
REQ-022 STROBE (STROBE_CYC cycles, counter): RCH_ low if read, else WCH_ low and CHWL_ = ~wdata; ch_addr stable.
REQ-023 Read capture: rdata <= ~CHOR_ at the edge ending the last STROBE cycle.
REQ-024 DONE (1 cycle): done[k] high, strobes high, CHWL_ all ones; then IDLE.
REQ-025 Latency: req sampled at cycle 0 -> done at cycle 2+STROBE_CYC (cycle 4 at default); IDLE again at 3+STROBE_CYC.
REQ-026 Requester inputs SHALL be ignored after ADDR latch; withdrawing req mid-transaction does not abort it.
REQ-027 req still high in the IDLE cycle after DONE counts as a new request and competes normally.
REQ-028 Simultaneous requests: exactly one granted per transaction; no requester starves beyond NREQ-1 transactions.
REQ-029 RCH_ and WCH_ SHALL never be low together, and never low outside STROBE.

Reset
REQ-030 rst asserted at any time, including mid-STROBE, immediately forces: state IDLE, RCH_=WCH_=1, CHWL_=all ones, gnt=0, done=0, rdata=0, ch_addr=0, RR pointer=0.
REQ-031 First request may be sampled in the first IDLE cycle after rst deasserts.

Configuration
REQ-032 Macro CHAN_LOCK_EN: when defined, if lock[k] and req[k] are high in DONE, next state is ADDR for requester k without arbitration, RR pointer unchanged.
REQ-033 Without CHAN_LOCK_EN, lock is present but ignored; DONE always returns to IDLE.
REQ-034 Locked chains are unlimited; lock dropped or req low in DONE returns to IDLE and arbitration resumes.

Structure
REQ-035 Package chan_arb_pkg SHALL hold CHAN_W=6, DATA_W=15, default NREQ, and the FSM state enum.
REQ-036 Round-robin selection SHALL be a sub-module rr_arbiter (req, pointer -> one-hot grant, valid).

Verification
REQ-037 Single read: req[0], chan=030, CHOR_=~15'o12345 -> RCH_ low cycles 2-3, done[0] cycle 4, rdata=15'o12345.
REQ-038 Single write: req[2], we=1, chan=011, wdata=15'o07070 -> WCH_ low 2 cycles, CHWL_=~15'o07070 during strobe, ch_addr=011.
REQ-039 All four req held high -> grants in order 0,1,2,3,0; each done exactly once per round.
REQ-040 rst pulsed mid-STROBE of a write -> WCH_ high and gnt=0 same cycle; next req granted to index 0.
REQ-041 CHAN_LOCK_EN, lock[1]+req[1] held with req[0] high -> three back-to-back transactions to 1 (DONE->ADDR), then 0 granted after lock drops; without macro 1 and 0 alternate.
